// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store ports with data priority and a starvation guard
module mem_arbiter #(
    parameter int WORD_LEN     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_ready,
    output logic                i_valid,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_ready,
    output logic                d_valid,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                mem_cmd_valid,
    output logic [WORD_LEN-1:0] mem_cmd_addr,
    output logic                mem_cmd_wen,
    output logic [WORD_LEN-1:0] mem_cmd_wdata,
    input  logic                mem_cmd_ready,
    input  logic                mem_rvalid,
    input  logic [WORD_LEN-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [3:0]          starve_q, starve_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                i_ready_q, i_ready_d;
    logic                i_valid_q, i_valid_d;
    logic [WORD_LEN-1:0] i_rdata_q, i_rdata_d;
    logic                d_ready_q, d_ready_d;
    logic                d_valid_q, d_valid_d;
    logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
    logic                d_win;
    // owner_q is 1 when the data port owns the current transaction
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        cmd_valid_d = cmd_valid_q;
        i_ready_d   = 1'b0;
        i_valid_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ready_d   = 1'b0;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_win       = d_req && !(i_req && starve_q == LIMIT);
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d     = d_win;
                    addr_d      = d_win ? d_addr : i_addr;
                    wen_d       = d_win && d_wen;
                    wdata_d     = d_win ? d_wdata : '0;
                    starve_d    = (d_win && i_req) ? ((starve_q == LIMIT) ? starve_q : starve_q + 4'd1) : 4'd0;
                    i_ready_d   = !d_win;
                    d_ready_d   = d_win;
                    cmd_valid_d = 1'b1;
                    state_d     = CMD;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    d_valid_d   = wen_q;
                    d_rdata_d   = wen_q ? '0 : d_rdata_q;
                    state_d     = wen_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    i_valid_d = !owner_q;
                    d_valid_d = owner_q;
                    i_rdata_d = owner_q ? i_rdata_q : mem_rdata;
                    d_rdata_d = owner_q ? mem_rdata : d_rdata_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            starve_q    <= 4'd0;
            cmd_valid_q <= 1'b0;
            i_ready_q   <= 1'b0;
            i_valid_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            cmd_valid_q <= cmd_valid_d;
            i_ready_q   <= i_ready_d;
            i_valid_q   <= i_valid_d;
            i_rdata_q   <= i_rdata_d;
            d_ready_q   <= d_ready_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
    assign i_ready       = i_ready_q;
    assign i_valid       = i_valid_q;
    assign i_rdata       = i_rdata_q;
    assign d_ready       = d_ready_q;
    assign d_valid       = d_valid_q;
    assign d_rdata       = d_rdata_q;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_wen   = wen_q;
    assign mem_cmd_wdata = wdata_q;
endmodule
